// File: rtl/hazard_pkg.sv
// Shared register-file geometry and scoreboard FSM encoding.
// Pure declarations: no latency, no backpressure.
package hazard_pkg;
  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } sb_state_e;
endpackage

// File: rtl/sb_counter.sv
// Saturating up/down count of in-flight long-latency writes; clear wins, inc+dec holds.
// One-cycle registered update; never exceeds MAX and never wraps below zero.
module sb_counter
  import hazard_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = REG_IDX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && (cnt_q < W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: combinational stall on RAW/WAW/capacity/drain, registered busy state.
// SCOREBOARD_BYPASS_EN forwards a same-cycle writeback past the hazard check.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instruction_vld,
  input  logic [REG_IDX_W-1:0] rs1_index,
  input  logic [REG_IDX_W-1:0] rs2_index,
  input  logic [REG_IDX_W-1:0] rd_index,
  input  logic                 rs1_mark,
  input  logic                 rs2_mark,
  input  logic                 rd_mark,
  input  logic                 rd_long_mark,
  input  logic                 wb_vld,
  input  logic [REG_IDX_W-1:0] wb_index,
  input  logic                 flush,
  input  logic                 drain_req,
  output logic                 conflict,
  output logic                 drain_done,
  output logic [REG_NUM-1:0]   busy_vec,
  output logic [REG_IDX_W-1:0] outstanding,
  output logic                 wb_err
);

  localparam logic [REG_IDX_W-1:0] MAX_CNT = REG_IDX_W'(MAX_OUTSTANDING);

  logic [REG_NUM-1:0] busy_q, busy_d, busy_chk, wb_onehot;
  sb_state_e          state_q, state_d;
  logic               wb_err_q, wb_err_d;
  logic               hazard_src, hazard_waw, cap_full, drain_stall;
  logic               issue, wb_hit, wb_bad;

  always_comb begin
    wb_onehot = '0;
    if (wb_vld) wb_onehot[wb_index] = 1'b1;
  end

`ifdef SCOREBOARD_BYPASS_EN
  assign busy_chk = busy_q & ~wb_onehot;
`else
  assign busy_chk = busy_q;
`endif

  assign hazard_src  = (rs1_mark & busy_chk[rs1_index]) | (rs2_mark & busy_chk[rs2_index]);
  assign hazard_waw  = rd_mark & busy_chk[rd_index];
  assign cap_full    = rd_long_mark & (outstanding == MAX_CNT);
  assign drain_stall = (state_q == DRAIN);
  assign conflict    = instruction_vld & (hazard_src | hazard_waw | cap_full | drain_stall);

  assign issue  = rd_long_mark & ~conflict & (rd_index != '0);
  assign wb_hit = wb_vld & (wb_index != '0) & busy_q[wb_index];
  assign wb_bad = wb_vld & ~wb_hit;

  // Clear before set so an issue to the register being written back stays pending.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wb_hit) busy_d[wb_index] = 1'b0;
      if (issue)  busy_d[rd_index] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  assign wb_err_d = wb_err_q | (wb_bad & ~flush);

  always_comb begin
    state_d    = state_q;
    drain_done = 1'b0;
    case (state_q)
      RUN:   if (drain_req) state_d = DRAIN;
      DRAIN: if (outstanding == '0) begin
        state_d    = RUN;
        drain_done = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (flush) begin
      state_d    = RUN;
      drain_done = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      state_q  <= RUN;
      wb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      state_q  <= state_d;
      wb_err_q <= wb_err_d;
    end
  end

  sb_counter #(
    .MAX (MAX_OUTSTANDING),
    .W   (REG_IDX_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (issue),
    .dec_i (wb_hit),
    .cnt_o (outstanding)
  );

  assign busy_vec = busy_q;
  assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenarios plus randomized traffic against a per-register pending model.
module tb_hazard_scoreboard;

  localparam int MAXO = 4;
`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        instruction_vld;
  logic [4:0]  rs1_index, rs2_index, rd_index, wb_index;
  logic        rs1_mark, rs2_mark, rd_mark, rd_long_mark;
  logic        wb_vld, flush, drain_req;
  logic        conflict, drain_done, wb_err;
  logic [31:0] busy_vec;
  logic [4:0]  outstanding;

  hazard_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk             (clk),
    .rst             (rst),
    .instruction_vld (instruction_vld),
    .rs1_index       (rs1_index),
    .rs2_index       (rs2_index),
    .rd_index        (rd_index),
    .rs1_mark        (rs1_mark),
    .rs2_mark        (rs2_mark),
    .rd_mark         (rd_mark),
    .rd_long_mark    (rd_long_mark),
    .wb_vld          (wb_vld),
    .wb_index        (wb_index),
    .flush           (flush),
    .drain_req       (drain_req),
    .conflict        (conflict),
    .drain_done      (drain_done),
    .busy_vec        (busy_vec),
    .outstanding     (outstanding),
    .wb_err          (wb_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state: which registers await a long write, how many, draining, error seen.
  bit   m_busy[32];
  int   m_cnt;
  bit   m_drain;
  bit   m_err;
  logic obs_conf, obs_dd;

  function automatic void model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_cnt   = 0;
    m_drain = 1'b0;
    m_err   = 1'b0;
  endfunction

  function automatic bit pend(input int idx);
    return m_busy[idx] && !(BYP && wb_vld && (int'(wb_index) == idx));
  endfunction

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic idle();
    instruction_vld = 0; rs1_index = 0; rs2_index = 0; rd_index = 0;
    rs1_mark = 0; rs2_mark = 0; rd_mark = 0; rd_long_mark = 0;
    wb_vld = 0; wb_index = 0; flush = 0; drain_req = 0;
  endtask

  task automatic instr(input int r1, input bit m1, input int r2, input bit m2,
                       input int rd, input bit mrd, input bit lng);
    instruction_vld = 1'b1;
    rs1_index = 5'(r1); rs1_mark = m1;
    rs2_index = 5'(r2); rs2_mark = m2;
    rd_index  = 5'(rd); rd_mark  = mrd; rd_long_mark = lng;
  endtask

  task automatic set_wb(input bit v, input int idx);
    wb_vld = v; wb_index = 5'(idx);
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registered outputs.
  task automatic tick(input string tag);
    bit ec, ei, wok, edd;
    @(negedge clk); #1;
    ec = instruction_vld && ((rs1_mark && pend(rs1_index)) || (rs2_mark && pend(rs2_index)) ||
                             (rd_mark && pend(rd_index)) || (rd_long_mark && m_cnt == MAXO) || m_drain);
    ei  = rd_long_mark && !ec && (rd_index != 0);
    wok = wb_vld && (wb_index != 0) && m_busy[wb_index];
    edd = m_drain && (m_cnt == 0) && !flush;
    obs_conf = conflict;
    obs_dd   = drain_done;
    check({tag, ".conflict"}, conflict, ec);
    check({tag, ".drain_done"}, drain_done, edd);
    @(posedge clk); #1;
    if (flush) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_cnt   = 0;
      m_drain = 1'b0;
    end else begin
      if (wok) begin m_busy[wb_index] = 1'b0; m_cnt--; end
      if (wb_vld && !wok) m_err = 1'b1;
      if (ei) begin m_busy[rd_index] = 1'b1; m_cnt++; end
      if (!m_drain && drain_req) m_drain = 1'b1;
      else if (m_drain && edd) m_drain = 1'b0;
    end
    check({tag, ".busy_vec"}, busy_vec, model_vec());
    check({tag, ".outstanding"}, outstanding, m_cnt);
    check({tag, ".wb_err"}, wb_err, m_err);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    instruction_vld = 1'b1; rd_long_mark = 1'b1; rd_index = 5'd9;
    #1;
    check("rst.busy_vec", busy_vec, 0);
    check("rst.outstanding", outstanding, 0);
    check("rst.wb_err", wb_err, 0);
    check("rst.drain_done", drain_done, 0);
    check("rst.conflict", conflict, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; idle();
    @(posedge clk); #1;

    // Long op then dependent read
    instr(0, 0, 0, 0, 5, 1, 1);          tick("r20_mul");
    instr(5, 1, 0, 0, 0, 0, 0);          tick("r20_dep");
    check("r20_dep_stall", obs_conf, 1);
    set_wb(1, 5);                        tick("r20_wb");
    check("r20_wb_cycle", obs_conf, BYP ? 0 : 1);
    set_wb(0, 0);                        tick("r20_after");
    check("r20_after_free", obs_conf, 0);

    // Capacity limit
    idle();
    for (int i = 1; i <= 4; i++) begin instr(0, 0, 0, 0, i, 1, 1); tick("r21_fill"); end
    instr(0, 0, 0, 0, 6, 1, 1);          tick("r21_full");
    check("r21_full_stall", obs_conf, 1);
    check("r21_full_cnt", outstanding, 4);
    idle(); set_wb(1, 1);                tick("r21_wb");
    set_wb(0, 0); instr(0, 0, 0, 0, 6, 1, 1); tick("r21_fifth");
    check("r21_fifth_go", obs_conf, 0);
    check("r21_fifth_cnt", outstanding, 4);

    // Drain with two ops in flight
    idle(); set_wb(1, 2);                tick("r22_wb2");
    set_wb(1, 3);                        tick("r22_wb3");
    check("r22_two_left", outstanding, 2);
    set_wb(0, 0); drain_req = 1'b1;      tick("r22_req");
    drain_req = 1'b0; instr(10, 1, 0, 0, 0, 0, 0); tick("r22_hold");
    check("r22_hold_stall", obs_conf, 1);
    set_wb(1, 4);                        tick("r22_wb4");
    set_wb(1, 6);                        tick("r22_wb6");
    check("r22_no_early_done", obs_dd, 0);
    set_wb(0, 0);                        tick("r22_done");
    check("r22_done_pulse", obs_dd, 1);
    tick("r22_run");
    check("r22_pulse_gone", obs_dd, 0);
    check("r22_run_free", obs_conf, 0);

    // x0 never tracked; stray writeback is sticky error
    instr(0, 0, 0, 0, 0, 1, 1);          tick("r23_x0");
    check("r23_x0_busy", busy_vec, 0);
    check("r23_x0_cnt", outstanding, 0);
    idle(); set_wb(1, 7);                tick("r23_stray");
    check("r23_err_set", wb_err, 1);
    idle();
    repeat (3) tick("r23_idle");
    check("r23_err_held", wb_err, 1);

    // Issue and writeback to the same register
    instr(0, 0, 0, 0, 3, 1, 1);          tick("r24_div");
    instr(0, 0, 0, 0, 3, 0, 1); set_wb(1, 3); tick("r24_same");
    check("r24_busy3", busy_vec[3], 1);
    check("r24_cnt", outstanding, 1);

    // Flush, then reset in the middle of a drain
    idle(); instr(0, 0, 0, 0, 8, 1, 1);  tick("r25_i8");
    instr(0, 0, 0, 0, 9, 1, 1);          tick("r25_i9");
    check("r25_three", outstanding, 3);
    idle(); flush = 1'b1;                tick("r25_flush");
    check("r25_flush_busy", busy_vec, 0);
    check("r25_flush_cnt", outstanding, 0);
    check("r25_flush_keeps_err", wb_err, 1);
    flush = 1'b0;
    instr(0, 0, 0, 0, 11, 1, 1);         tick("r25_i11");
    instr(0, 0, 0, 0, 12, 1, 1);         tick("r25_i12");
    idle(); drain_req = 1'b1;            tick("r25_dreq");
    drain_req = 1'b0;                    tick("r25_draining");
    @(negedge clk);
    instruction_vld = 1'b1; rst = 1'b1;
    #1;
    check("r25_rst_busy", busy_vec, 0);
    check("r25_rst_cnt", outstanding, 0);
    check("r25_rst_err", wb_err, 0);
    check("r25_rst_dd", drain_done, 0);
    check("r25_rst_conf", conflict, 0);
    model_reset();
    @(posedge clk); #1;
    check("r25_rst_dd_edge", drain_done, 0);
    @(negedge clk); rst = 1'b0; idle();
    @(posedge clk); #1;

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      bit v, lng;
      idle();
      v   = ($urandom % 4) != 0;
      lng = v && (($urandom % 3) == 0);
      if (v) instr($urandom % 16, $urandom % 2, $urandom % 16, $urandom % 2,
                   (($urandom % 8) == 0) ? 0 : ($urandom % 16),
                   lng ? 1'b1 : 1'($urandom % 2), lng);
      if (m_cnt > 0 && ($urandom % 3) == 0) begin
        int s = $urandom % 32;
        for (int k = 0; k < 32; k++) begin
          if (m_busy[(s + k) % 32]) begin set_wb(1, (s + k) % 32); break; end
        end
      end else if (($urandom % 40) == 0) begin
        set_wb(1, $urandom % 32);
      end
      if (!wb_vld && ($urandom % 80) == 0) flush = 1'b1;
      if (($urandom % 30) == 0) drain_req = 1'b1;
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, giving the maximum in-flight long-latency writes (LOAD/MUL/DIV); legal range 1..31.
REQ-002 SHALL have ports, clock and reset first, each as name, direction, width and meaning:
- clk  in  1  sole clock; all state on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- instruction_vld  in  1  decoded instruction present.
- rs1_index, rs2_index, rd_index  in  5 each  register indices from decode.
- rs1_mark, rs2_mark, rd_mark, rd_long_mark  in  1 each  usage marks from decode, already gated with instruction_vld.
- wb_vld  in  1  long-latency unit completes a write.
- wb_index  in  5  register being written back.
- flush  in  1  kill all in-flight long ops.
- drain_req  in  1  level request to empty the pipeline (CSR/MRET/ECALL).
- conflict  out  1  stall decoded instruction (combinational).
- drain_done  out  1  one-cycle pulse, drain complete.
- busy_vec  out  32  registered per-register pending-write bits.
- outstanding  out  5  registered in-flight long-op count.
- wb_err  out  1  sticky protocol-error flag.

Function
REQ-003 SHALL compute issue = rd_long_mark & ~conflict & (rd_index != 0).
REQ-004 SHALL assert conflict = instruction_vld & (hazard_src | hazard_waw | cap_full | drain_stall).
- hazard_src = (rs1_mark & busy[rs1_index]) | (rs2_mark & busy[rs2_index]).
- hazard_waw = rd_mark & busy[rd_index].
- cap_full = rd_long_mark & (outstanding == MAX_OUTSTANDING).
- drain_stall = (state == DRAIN).
REQ-005 SHALL hold busy[0] at 0 permanently; index 0 is never tracked.
REQ-006 SHALL, on issue, set busy[rd_index] and increment outstanding; both are visible the next cycle.
REQ-007 SHALL, on wb_vld with busy[wb_index]=1 and wb_index != 0, clear busy[wb_index] and decrement outstanding.
REQ-008 SHALL, on wb_vld with busy[wb_index]=0 or wb_index=0, leave state unchanged and set wb_err.
REQ-009 SHALL leave outstanding unchanged on simultaneous issue and valid writeback.
REQ-010 SHALL give the set priority when issue and writeback target the same index: busy stays 1 and the count is unchanged.
REQ-011 SHALL provide FSM states RUN and DRAIN.
- RUN -> DRAIN when drain_req=1.
- DRAIN -> RUN when outstanding==0, pulsing drain_done for exactly that cycle.
- A drain_req arriving with outstanding==0 still enters DRAIN and completes on the following cycle.
REQ-012 SHALL have flush take priority over issue, writeback and the FSM: it clears busy_vec and outstanding and forces RUN next cycle. flush does not pulse drain_done and does not clear wb_err.
REQ-013 SHALL never let outstanding exceed MAX_OUTSTANDING or wrap below 0.

Reset
REQ-014 SHALL, while rst=1, immediately force busy_vec=0, outstanding=0, state=RUN, drain_done=0 and wb_err=0, including when asserted mid-drain or with ops in flight.
REQ-015 SHALL make conflict depend only on inputs during reset; with cleared state it equals instruction_vld & 0 = 0.
REQ-016 SHALL clear wb_err only by reset.

Configuration
REQ-017 SHALL honour macro SCOREBOARD_BYPASS_EN.
- Defined: hazard_src and hazard_waw exclude a register for which wb_vld=1 and wb_index matches in the same cycle (writeback forwarding).
- Undefined: that hazard persists until the cycle after the writeback.

Structure
REQ-018 SHALL take REG_NUM=32, REG_IDX_W=5 and the RUN/DRAIN state encoding from shared package hazard_pkg.
REQ-019 SHALL isolate the saturating up/down outstanding counter in sub-module sb_counter; all other logic stays in hazard_scoreboard.

Verification
REQ-020 Long issue then dependent: issue MUL with rd=5, next cycle rs1_mark with rs1=5 -> conflict=1; wb_vld with wb_index=5 -> conflict=0 the next cycle without bypass, the same cycle with SCOREBOARD_BYPASS_EN.
REQ-021 Capacity: 4 LOADs to x1..x4, then a 5th LOAD to x6 -> conflict=1 and outstanding=4; one writeback -> the 5th LOAD issues and outstanding returns to 4.
REQ-022 Drain: outstanding=2, drain_req=1 -> conflict=1 on every valid instruction; second writeback -> drain_done pulses 1 cycle, state RUN.
REQ-023 x0 and errors: LOAD with rd=0 -> busy_vec=0 and outstanding=0; wb_vld with wb_index=7 while not busy -> wb_err=1, held until rst.
REQ-024 Simultaneous events: issue DIV rd=3 while writeback of x3 in the same cycle -> busy[3]=1 and outstanding unchanged.
REQ-025 Flush and reset: outstanding=3 with flush=1 -> busy_vec=0 and outstanding=0 next cycle; rst asserted mid-DRAIN -> all outputs 0 immediately, no drain_done.
